// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out signal bundle of the PS/2 key-event controller.
// The slave modport is the controller; the master modport is the byte source plus event consumer.
interface ps2_key_event_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_ready;
  logic       overflow;
  logic       clr_ovf;
  logic       busy;

  modport slave (
    input  rx_valid, rx_data, evt_ready, clr_ovf,
    output evt_valid, evt_code, evt_ext, evt_break, overflow, busy
  );

  modport master (
    output rx_valid, rx_data, evt_ready, clr_ovf,
    input  evt_valid, evt_code, evt_ext, evt_break, overflow, busy
  );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// Turns raw PS/2 scan-code bytes into {code, ext, break} key events (E0/F0 prefixes,
// discard bytes, stale-prefix timeout) and queues them in a small FWFT FIFO.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_key_event_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TIMEOUT_W-1:0] TERM_CNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  state_t               state, state_n;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 timeout;
  logic                 push_req;
  evt_t                 push_evt;

  evt_t                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, do_push, do_pop, drop;
  logic                 ovf_q;
  evt_t                 head;

  // A byte arriving on the terminal-count cycle suppresses the timeout.
  assign timeout = (state != IDLE) && (tmo_cnt == TERM_CNT) && !bus.rx_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_n;
      if (bus.rx_valid || state == IDLE || timeout) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    push_req = 1'b0;
    push_evt = '0;
    if (timeout) begin
      state_n = IDLE;
    end else if (bus.rx_valid) begin
      if (bus.rx_data == 8'hE0) begin
        state_n = EXT;
      end else if (bus.rx_data == 8'hF0) begin
        case (state)
          IDLE, BRK: state_n = BRK;
          default:   state_n = EXT_BRK;
        endcase
      end else if (is_discard(bus.rx_data)) begin
        state_n = IDLE;
      end else begin
        push_req      = 1'b1;
        push_evt.code = bus.rx_data;
        push_evt.ext  = (state == EXT) || (state == EXT_BRK);
        push_evt.brk  = (state == BRK) || (state == EXT_BRK);
        state_n       = IDLE;
      end
    end
  end

  assign bus.busy = (state != IDLE);

  // FIFO: a pop frees a slot in the same cycle, so push-while-full succeeds if popping.
  assign full    = (count == FULL_CNT);
  assign do_pop  = bus.evt_valid && bus.evt_ready;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  // NOTE: the storage array has no reset; stale entries are never visible because
  // the head fields are gated by a reset count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.evt_valid = (count != '0);
  assign bus.evt_code  = bus.evt_valid ? head.code : 8'h00;
  assign bus.evt_ext   = bus.evt_valid && head.ext;
  assign bus.evt_break = bus.evt_valid && head.brk;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: prefix decoding, discards, timeout,
// FIFO full/overflow behaviour and asynchronous reset.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ps2_key_event_ctrl_if bus ();

  ps2_key_event_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_W     (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte for one clock; returns on the negedge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Check the head event fields, then pop it with a one-cycle evt_ready.
  task automatic expect_pop(input string tag, input logic [7:0] code, input logic ext,
                            input logic brk);
    check({tag, "_valid"}, bus.evt_valid, 1);
    check({tag, "_code"},  bus.evt_code,  code);
    check({tag, "_ext"},   bus.evt_ext,   ext);
    check({tag, "_brk"},   bus.evt_break, brk);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.evt_valid, 0);
    check({tag, "_code"},  bus.evt_code,  0);
    check({tag, "_ext"},   bus.evt_ext,   0);
    check({tag, "_brk"},   bus.evt_break, 0);
    check({tag, "_ovf"},   bus.overflow,  0);
    check({tag, "_busy"},  bus.busy,      0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes [5];
    codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst_n         = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.evt_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: plain make, then break, with evt_ready held high
    bus.evt_ready = 1'b1;
    send_byte(8'h1C);
    check("t1_make_valid", bus.evt_valid, 1);
    check("t1_make_code",  bus.evt_code,  8'h1C);
    check("t1_make_brk",   bus.evt_break, 0);
    send_byte(8'hF0);
    check("t1_f0_busy",    bus.busy,      1);
    check("t1_f0_empty",   bus.evt_valid, 0);
    send_byte(8'h1C);
    check("t1_brk_valid",  bus.evt_valid, 1);
    check("t1_brk_code",   bus.evt_code,  8'h1C);
    check("t1_brk_ext",    bus.evt_ext,   0);
    check("t1_brk_brk",    bus.evt_break, 1);
    check("t1_brk_busy",   bus.busy,      0);
    @(negedge clk);
    bus.evt_ready = 1'b0;
    check("t1_drained",    bus.evt_valid, 0);

    // 2: extended make, extended break, repeated E0
    send_byte(8'hE0);
    check("t2_e0_busy", bus.busy, 1);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    expect_pop("t2_ext_make", 8'h75, 1, 0);
    expect_pop("t2_ext_brk",  8'h75, 1, 1);
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    expect_pop("t2_e0e0", 8'h75, 1, 1);
    check("t2_empty", bus.evt_valid, 0);

    // 3: discard bytes, FE aborts a pending break
    send_byte(8'hAA);
    send_byte(8'hFA);
    check("t3_disc_empty", bus.evt_valid, 0);
    check("t3_disc_busy",  bus.busy,      0);
    send_byte(8'hF0);
    check("t3_f0_busy",    bus.busy,      1);
    send_byte(8'hFE);
    check("t3_fe_busy",    bus.busy,      0);
    check("t3_fe_empty",   bus.evt_valid, 0);
    send_byte(8'h1C);
    expect_pop("t3_after", 8'h1C, 0, 0);
    check("t3_empty", bus.evt_valid, 0);

    // 4a: prefix abandoned exactly TMO clocks after E0
    send_byte(8'hE0);
    repeat (TMO - 1) @(negedge clk);
    check("t4_busy_before_tmo", bus.busy, 1);
    @(negedge clk);
    check("t4_busy_after_tmo",  bus.busy, 0);
    send_byte(8'h1C);
    expect_pop("t4_after_tmo", 8'h1C, 0, 0);

    // 4b: byte on the terminal-count cycle is still extended
    send_byte(8'hE0);
    repeat (TMO - 2) @(negedge clk);
    check("t4_busy_pre_term", bus.busy, 1);
    send_byte(8'h1C);
    check("t4_term_busy", bus.busy, 0);
    expect_pop("t4_term_evt", 8'h1C, 1, 0);

    // 5: fill past depth, push while full with pop, clear vs. drop race
    foreach (codes[i]) send_byte(codes[i]);
    check("t5_ovf_set",  bus.overflow, 1);
    check("t5_head",     bus.evt_code, 8'h11);
    @(negedge clk);
    bus.evt_ready = 1'b1;
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'h66;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    bus.rx_valid  = 1'b0;
    check("t5_pushpop_head", bus.evt_code, 8'h22);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("t5_ovf_cleared", bus.overflow, 0);
    bus.clr_ovf  = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    @(negedge clk);
    bus.clr_ovf  = 1'b0;
    bus.rx_valid = 1'b0;
    check("t5_set_wins", bus.overflow, 1);
    expect_pop("t5_q0", 8'h22, 0, 0);
    expect_pop("t5_q1", 8'h33, 0, 0);
    expect_pop("t5_q2", 8'h44, 0, 0);
    expect_pop("t5_q3", 8'h66, 0, 0);
    check("t5_empty",      bus.evt_valid, 0);
    check("t5_empty_code", bus.evt_code,  0);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;

    // 6: asynchronous reset mid-sequence with events queued
    send_byte(8'h2A);
    send_byte(8'h3B);
    send_byte(8'hE0);
    check("t6_pre_busy",  bus.busy,      1);
    check("t6_pre_valid", bus.evt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h1C);
    expect_pop("t6_after", 8'h1C, 0, 0);
    check("t6_empty", bus.evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
